// File: rtl/exe_lane_cfg_ctrl_if.sv
// Bundle of config-handshake and per-lane issue/writeback signals
// shared by the lane configuration controller and its environment.
interface exe_lane_cfg_ctrl_if #(
    parameter int ISSUE_WIDTH = 4
);
    logic                   cfgReq_i;
    logic [ISSUE_WIDTH-1:0] cfgLaneMask_i;
    logic                   cfgAck_o;
    logic                   cfgErr_o;
    logic                   cfgBusy_o;
    logic [ISSUE_WIDTH-1:0] issueValid_i;
    logic [ISSUE_WIDTH-1:0] wbValid_i;
    logic                   recoverFlag_i;
    logic                   exceptionFlag_i;
    logic [ISSUE_WIDTH-1:0] issueBlock_o;
    logic [ISSUE_WIDTH-1:0] laneActive_o;

    modport master (
        output cfgReq_i, cfgLaneMask_i, issueValid_i, wbValid_i,
               recoverFlag_i, exceptionFlag_i,
        input  cfgAck_o, cfgErr_o, cfgBusy_o, issueBlock_o, laneActive_o
    );

    modport slave (
        input  cfgReq_i, cfgLaneMask_i, issueValid_i, wbValid_i,
               recoverFlag_i, exceptionFlag_i,
        output cfgAck_o, cfgErr_o, cfgBusy_o, issueBlock_o, laneActive_o
    );
endinterface

// File: rtl/exe_lane_cfg_ctrl.sv
// Sequences enabling/disabling of execution lanes: blocks issue, drains
// in-flight ops, then gates lanes off; newly enabled lanes settle before issue.
module exe_lane_cfg_ctrl #(
    parameter int ISSUE_WIDTH   = 4,
    parameter int CNT_W         = 3,
    parameter int WAKE_CYCLES   = 4,
    parameter int DRAIN_TIMEOUT = 64
) (
    input logic                clk,
    input logic                reset,
    exe_lane_cfg_ctrl_if.slave laneIf
);
    localparam int TMR_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WAKE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, stateNext;

    logic [ISSUE_WIDTH-1:0][CNT_W-1:0] inFlight, inFlightNext;
    logic [ISSUE_WIDTH-1:0] laneActive, laneActiveNext;
    logic [ISSUE_WIDTH-1:0] issueBlock, issueBlockNext;
    logic [ISSUE_WIDTH-1:0] offMask, offMaskNext;
    logic [ISSUE_WIDTH-1:0] onMask, onMaskNext;
    logic [ISSUE_WIDTH-1:0] reqTgt, reqOff, reqOn;
    logic [TMR_W-1:0]       timer, timerNext;
    logic [WAKE_W-1:0]      wakeCnt, wakeCntNext;
    logic                   errFlag, errFlagNext;
    logic                   ack, ackNext;
    logic                   errOut, errOutNext;
    logic                   flush;
    logic                   drainClear;

    assign flush = laneIf.recoverFlag_i | laneIf.exceptionFlag_i;

    // Saturating in-flight tracking; a flush wipes every lane's count.
    always_comb begin
        inFlightNext = inFlight;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (flush) begin
                inFlightNext[i] = '0;
            end else if (laneIf.issueValid_i[i] && !laneIf.wbValid_i[i] &&
                         inFlight[i] != CNT_MAX) begin
                inFlightNext[i] = inFlight[i] + CNT_W'(1);
            end else if (!laneIf.issueValid_i[i] && laneIf.wbValid_i[i] &&
                         inFlight[i] != '0) begin
                inFlightNext[i] = inFlight[i] - CNT_W'(1);
            end
        end
    end

    // Lanes being turned off are quiet only when empty and not taking a new op.
    always_comb begin
        drainClear = 1'b1;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (offMask[i] && (inFlight[i] != '0 || laneIf.issueValid_i[i])) begin
                drainClear = 1'b0;
            end
        end
    end

    always_comb begin
        reqTgt = laneIf.cfgLaneMask_i | ISSUE_WIDTH'(1);
        reqOff = laneActive & ~reqTgt;
        reqOn  = reqTgt & ~laneActive;

        stateNext      = state;
        laneActiveNext = laneActive;
        issueBlockNext = issueBlock;
        offMaskNext    = offMask;
        onMaskNext     = onMask;
        timerNext      = timer;
        wakeCntNext    = wakeCnt;
        errFlagNext    = errFlag;
        ackNext        = 1'b0;
        errOutNext     = 1'b0;

        case (state)
            IDLE: begin
                if (laneIf.cfgReq_i) begin
                    offMaskNext    = reqOff;
                    onMaskNext     = reqOn;
                    timerNext      = '0;
                    wakeCntNext    = '0;
                    errFlagNext    = 1'b0;
                    issueBlockNext = issueBlock | reqOff;
                    if (reqOff != '0) begin
                        stateNext = DRAIN;
                    end else if (reqOn != '0) begin
                        stateNext      = WAKE;
                        laneActiveNext = laneActive | reqOn;
                        issueBlockNext = issueBlock | reqOn;
                    end else begin
                        stateNext = DONE;
                    end
                end
            end
            DRAIN: begin
                if (drainClear) begin
                    laneActiveNext = laneActive & ~offMask;
                    if (onMask != '0) begin
                        stateNext      = WAKE;
                        laneActiveNext = (laneActive & ~offMask) | onMask;
                        issueBlockNext = issueBlock | onMask;
                    end else begin
                        stateNext = DONE;
                    end
                end else if (timer == TMR_LAST) begin
                    // Abort: lanes stay powered, so issue to them may resume.
                    issueBlockNext = issueBlock & ~offMask;
                    errFlagNext    = 1'b1;
                    stateNext      = DONE;
                end else begin
                    timerNext = timer + TMR_W'(1);
                end
            end
            WAKE: begin
                if (wakeCnt == WAKE_LAST) begin
                    issueBlockNext = issueBlock & ~onMask;
                    stateNext      = DONE;
                end else begin
                    wakeCntNext = wakeCnt + WAKE_W'(1);
                end
            end
            DONE: begin
                ackNext    = 1'b1;
                errOutNext = errFlag;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            inFlight   <= '0;
            laneActive <= '1;
            issueBlock <= '0;
            offMask    <= '0;
            onMask     <= '0;
            timer      <= '0;
            wakeCnt    <= '0;
            errFlag    <= 1'b0;
            ack        <= 1'b0;
            errOut     <= 1'b0;
        end else begin
            state      <= stateNext;
            inFlight   <= inFlightNext;
            laneActive <= laneActiveNext;
            issueBlock <= issueBlockNext;
            offMask    <= offMaskNext;
            onMask     <= onMaskNext;
            timer      <= timerNext;
            wakeCnt    <= wakeCntNext;
            errFlag    <= errFlagNext;
            ack        <= ackNext;
            errOut     <= errOutNext;
        end
    end

    assign laneIf.laneActive_o = laneActive;
    assign laneIf.issueBlock_o = issueBlock;
    assign laneIf.cfgAck_o     = ack;
    assign laneIf.cfgErr_o     = errOut;
    assign laneIf.cfgBusy_o    = (state != IDLE);
endmodule

// File: tb/tb_exe_lane_cfg_ctrl.sv
// Directed bench for exe_lane_cfg_ctrl: disable, enable, drain with traffic,
// flush during drain, drain timeout, lane-0 forcing and mid-operation reset.
module tb_exe_lane_cfg_ctrl;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    exe_lane_cfg_ctrl_if #(.ISSUE_WIDTH(IW)) bus ();

    exe_lane_cfg_ctrl #(
        .ISSUE_WIDTH(IW), .CNT_W(3), .WAKE_CYCLES(4), .DRAIN_TIMEOUT(64)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .laneIf (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic waitAck(input string tag, input int maxCycles);
        int n = 0;
        while (bus.cfgAck_o !== 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        check1(tag, bus.cfgAck_o, 1'b1);
    endtask

    task automatic request(input logic [IW-1:0] mask);
        bus.cfgReq_i      = 1'b1;
        bus.cfgLaneMask_i = mask;
        tick();
        bus.cfgReq_i      = 1'b0;
    endtask

    initial begin
        reset               = 1'b0;
        bus.cfgReq_i        = 1'b0;
        bus.cfgLaneMask_i   = '0;
        bus.issueValid_i    = '0;
        bus.wbValid_i       = '0;
        bus.recoverFlag_i   = 1'b0;
        bus.exceptionFlag_i = 1'b0;

        tick();
        tick();
        check4("rst_active", bus.laneActive_o, 4'b1111);
        check4("rst_block", bus.issueBlock_o, 4'b0000);
        check1("rst_busy", bus.cfgBusy_o, 1'b0);
        check1("rst_ack", bus.cfgAck_o, 1'b0);
        reset = 1'b1;
        tick();

        // Disable lanes 2,3 with empty pipes
        request(4'b0011);
        check4("dis_block_e0", bus.issueBlock_o, 4'b1100);
        check4("dis_active_e0", bus.laneActive_o, 4'b1111);
        check1("dis_busy_e0", bus.cfgBusy_o, 1'b1);
        tick();
        check4("dis_active_e1", bus.laneActive_o, 4'b0011);
        check1("dis_ack_e1", bus.cfgAck_o, 1'b0);
        tick();
        check1("dis_ack_e2", bus.cfgAck_o, 1'b1);
        check1("dis_err_e2", bus.cfgErr_o, 1'b0);
        check4("dis_block_e2", bus.issueBlock_o, 4'b1100);
        check1("dis_busy_e2", bus.cfgBusy_o, 1'b0);
        tick();
        check1("dis_ack_gone", bus.cfgAck_o, 1'b0);

        // Re-enable lanes 2,3: settle window of four cycles
        request(4'b1111);
        check4("en_active_e0", bus.laneActive_o, 4'b1111);
        check4("en_block_e0", bus.issueBlock_o, 4'b1100);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check4("en_block_hold", bus.issueBlock_o, 4'b1100);
            check1("en_ack_hold", bus.cfgAck_o, 1'b0);
        end
        tick();
        check4("en_block_e4", bus.issueBlock_o, 4'b0000);
        check1("en_ack_e4", bus.cfgAck_o, 1'b0);
        tick();
        check1("en_ack_e5", bus.cfgAck_o, 1'b1);
        check1("en_err_e5", bus.cfgErr_o, 1'b0);
        tick();

        // Lane 3 with two ops in flight, disable it
        bus.issueValid_i = 4'b1000;
        tick();
        tick();
        bus.issueValid_i = '0;
        request(4'b0111);
        check4("dr3_block_e0", bus.issueBlock_o, 4'b1000);
        bus.issueValid_i = 4'b1000;
        bus.wbValid_i    = 4'b1000;
        tick();
        bus.issueValid_i = '0;
        bus.wbValid_i    = '0;
        check4("dr3_active_iw", bus.laneActive_o, 4'b1111);
        tick();
        check4("dr3_active_idle", bus.laneActive_o, 4'b1111);
        bus.wbValid_i = 4'b1000;
        tick();
        check4("dr3_active_wb1", bus.laneActive_o, 4'b1111);
        tick();
        bus.wbValid_i = '0;
        check4("dr3_active_wb2", bus.laneActive_o, 4'b1111);
        tick();
        check4("dr3_active_off", bus.laneActive_o, 4'b0111);
        tick();
        check1("dr3_ack", bus.cfgAck_o, 1'b1);
        check1("dr3_err", bus.cfgErr_o, 1'b0);
        check4("dr3_block", bus.issueBlock_o, 4'b1000);
        tick();

        // Lane 1 holding three ops, recovery flush during drain
        bus.issueValid_i = 4'b0010;
        repeat (3) tick();
        bus.issueValid_i = '0;
        request(4'b0101);
        check4("fl_block_e0", bus.issueBlock_o, 4'b1010);
        request(4'b0001);
        check4("fl_active_busyreq", bus.laneActive_o, 4'b0111);
        check1("fl_busy", bus.cfgBusy_o, 1'b1);
        bus.recoverFlag_i = 1'b1;
        tick();
        bus.recoverFlag_i = 1'b0;
        check4("fl_active_flush", bus.laneActive_o, 4'b0111);
        tick();
        check4("fl_active_off", bus.laneActive_o, 4'b0101);
        tick();
        check1("fl_ack", bus.cfgAck_o, 1'b1);
        tick();
        check1("fl_no_extra_ack", bus.cfgAck_o, 1'b0);
        check1("fl_idle", bus.cfgBusy_o, 1'b0);
        tick();
        check1("fl_no_extra_ack2", bus.cfgAck_o, 1'b0);
        check4("fl_active_final", bus.laneActive_o, 4'b0101);

        // Bring all lanes back
        request(4'b1111);
        waitAck("re_ack", 10);
        check4("re_active", bus.laneActive_o, 4'b1111);
        check4("re_block", bus.issueBlock_o, 4'b0000);
        tick();

        // Lane 2 stuck with one op: drain must time out
        bus.issueValid_i = 4'b0100;
        tick();
        bus.issueValid_i = '0;
        request(4'b0011);
        check4("to_block_e0", bus.issueBlock_o, 4'b1100);
        repeat (63) tick();
        check1("to_busy_63", bus.cfgBusy_o, 1'b1);
        check1("to_ack_63", bus.cfgAck_o, 1'b0);
        check4("to_block_63", bus.issueBlock_o, 4'b1100);
        tick();
        check4("to_block_64", bus.issueBlock_o, 4'b0000);
        check1("to_ack_64", bus.cfgAck_o, 1'b0);
        tick();
        check1("to_ack", bus.cfgAck_o, 1'b1);
        check1("to_err", bus.cfgErr_o, 1'b1);
        check4("to_active", bus.laneActive_o, 4'b1111);
        check4("to_block", bus.issueBlock_o, 4'b0000);
        tick();
        check1("to_ack_gone", bus.cfgAck_o, 1'b0);
        check1("to_err_gone", bus.cfgErr_o, 1'b0);

        // Exception flush overrides a same-cycle issue; mask 0 keeps lane 0
        bus.exceptionFlag_i = 1'b1;
        bus.issueValid_i    = 4'b0100;
        tick();
        bus.exceptionFlag_i = 1'b0;
        bus.issueValid_i    = '0;
        request(4'b0000);
        check4("l0_block_e0", bus.issueBlock_o, 4'b1110);
        tick();
        check4("l0_active_e1", bus.laneActive_o, 4'b0001);
        tick();
        check1("l0_ack", bus.cfgAck_o, 1'b1);
        check1("l0_err", bus.cfgErr_o, 1'b0);
        tick();

        // Reset in the middle of a wake sequence abandons it silently
        request(4'b1111);
        check1("mr_busy_e0", bus.cfgBusy_o, 1'b1);
        check4("mr_active_e0", bus.laneActive_o, 4'b1111);
        reset = 1'b0;
        tick();
        check1("mr_busy_rst", bus.cfgBusy_o, 1'b0);
        check4("mr_block_rst", bus.issueBlock_o, 4'b0000);
        check4("mr_active_rst", bus.laneActive_o, 4'b1111);
        reset = 1'b1;
        tick();
        tick();
        check1("mr_no_ack", bus.cfgAck_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/exe_lane_cfg_ctrl.md
Name: exe_lane_cfg_ctrl

Overview:
Sequences dynamic enabling and disabling of execution lanes (ExecutionPipe_SC instances) under DYNAMIC_CONFIG.
- On a reconfiguration request, blocks issue to lanes being turned off and drains their in-flight ops.
- Then drops their laneActive; newly enabled lanes get a wake-up settle period before issue is unblocked.
- Sits between the config/power manager, the issue queue and the per-lane execution pipes.

Parameters:
ISSUE_WIDTH, 4, number of execution lanes.
CNT_W, 3, width of each per-lane in-flight counter (max in-flight = 2^CNT_W-1).
WAKE_CYCLES, 4, settle cycles after enabling lanes before issue unblocks (>=1).
DRAIN_TIMEOUT, 64, max DRAIN cycles before abort (>=1).

Ports:
clk  in  1  core clock.
reset  in  1  synchronous, active-low reset (asserted when 0), sampled on the rising edge of clk.
cfgReq_i  in  1  one-cycle request to apply cfgLaneMask_i.
cfgLaneMask_i  in  ISSUE_WIDTH  requested active-lane mask (bit0 ignored, lane 0 always on).
cfgAck_o  out  1  one-cycle completion pulse.
cfgErr_o  out  1  valid with cfgAck_o: 1 = aborted by timeout.
cfgBusy_o  out  1  FSM not in IDLE.
issueValid_i  in  ISSUE_WIDTH  per-lane: packet accepted into RegRead this cycle.
wbValid_i  in  ISSUE_WIDTH  per-lane: writeback packet valid this cycle.
recoverFlag_i  in  1  branch recovery flush.
exceptionFlag_i  in  1  exception flush.
issueBlock_o  out  ISSUE_WIDTH  per-lane: issue queue must not issue to this lane.
laneActive_o  out  ISSUE_WIDTH  per-lane active/clock enable to the execution pipes.

Behaviour:
Reset (reset==0 at a clk edge):
- laneActive_o = all ones; issueBlock_o = 0; cfgAck_o = cfgErr_o = cfgBusy_o = 0.
- All counters cleared, state = IDLE.
- Reset mid-operation abandons the reconfiguration with no ack.

In-flight counters, one per lane, updated every cycle:
- +1 on issueValid_i[i], -1 on wbValid_i[i]; both in the same cycle = unchanged.
- Saturate at max and at 0, no wrap.
- recoverFlag_i|exceptionFlag_i clears all counters that cycle; this overrides any simultaneous issue/wb.

Derived masks, latched on request accept: tgt = cfgLaneMask_i | 1; offMask = laneActive_o & ~tgt; onMask = tgt & ~laneActive_o.

FSM, all outputs registered:
- IDLE: cfgReq_i accepted → latch tgt, offMask and onMask, set issueBlock_o |= offMask, then go to:
  - DRAIN if offMask != 0;
  - else WAKE if onMask != 0;
  - else DONE.
- cfgReq_i while not IDLE is ignored (no ack); the requester must wait for !cfgBusy_o.
- DRAIN: timer counts up from 0.
  - When all counters in offMask are 0 and there is no issueValid_i on offMask lanes this cycle, next cycle laneActive_o &= ~offMask. Then go to WAKE if onMask != 0, else DONE.
  - A flush during DRAIN empties the counters, so completion normally follows on the next cycle.
  - If the timer reaches DRAIN_TIMEOUT first: issueBlock_o &= ~offMask, laneActive_o unchanged, cfgErr_o=1, go to DONE.
- WAKE: on entry set laneActive_o |= onMask and issueBlock_o |= onMask. Hold WAKE_CYCLES cycles, then issueBlock_o &= ~onMask, go to DONE.
- DONE: cfgAck_o=1 for one cycle (cfgErr_o as set, else 0), then go to IDLE.
- cfgBusy_o = (state != IDLE).

Invariants:
- laneActive_o[0] is always 1.
- A lane is never deactivated while its counter is nonzero, except on the timeout path, where it stays active.
- issueBlock_o is 1 on any lane whose laneActive_o is 0.

Latency:
- Disable with an empty pipe: req → ack in 3 cycles (IDLE→DRAIN→DONE→ack).
- Enable only: 2+WAKE_CYCLES cycles.

Test Plan:
- Reset low 2 cycles → laneActive_o=4'b1111, issueBlock_o=0, cfgBusy_o=0.
- All lanes idle, cfgReq_i with mask 4'b0011 → issueBlock_o=4'b1100 next cycle, laneActive_o=4'b0011 two cycles later, cfgAck_o=1 with cfgErr_o=0, issueBlock_o still 4'b1100.
- Lane 3 holds 2 in flight, request mask 4'b0111 → laneActive_o[3] stays 1 until two wbValid_i[3] pulses have been seen, then clears; a simultaneous issue and wb on lane 3 leaves the count unchanged.
- From 4'b0011, request 4'b1111 → laneActive_o=4'b1111 immediately after accept, issueBlock_o=4'b1100 for exactly WAKE_CYCLES=4 cycles, then 0, then ack.
- Lane 2 counter held at 1 with no wb, request 4'b0011 → after 64 DRAIN cycles cfgAck_o=1, cfgErr_o=1, laneActive_o=4'b1111, issueBlock_o=0.
- Lane 1 in DRAIN with count 3, recoverFlag_i pulse → counter goes to 0, laneActive_o[1] clears the next cycle; a second cfgReq_i while busy produces no extra ack.
